// File: rtl/exec_pkg.sv
// Shared types and constants for the execute datapath.
//   alu_op_e   : ALU operation encodings
//   shift_op_e : shifter operation encodings
//   FLAG_*     : bit positions of N, Z, C, V inside the 4-bit flags vector {N,Z,C,V}
//   signed_ovf : two's-complement overflow of an addition from the operand/result sign bits
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_CMP = 3'b101,
        ALU_MOV = 3'b110,
        ALU_MVN = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Overflow of x + y: both addends share a sign and the result sign differs.
    // Subtraction passes the inverted sign of the subtrahend.
    function automatic logic signed_ovf(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

endpackage

// File: rtl/exec_shifter.sv
// Operand-B shifter for the execute stage.
// Build option: EXEC_SHIFT_ITER_EN selects an iterative 1-bit/cycle shifter;
// otherwise a single-cycle barrel shifter is built.
// Ports:
//   clk, rst, active : (iterative build only) clock, sync reset, EX holds an operation
//   op    : shift operation (LSL/LSR/ASR/ROR)
//   amt   : shift amount, already reduced to SH_W bits
//   din   : operand to shift
//   dout  : shifted result (valid when done)
//   cout  : last bit shifted out
//   c_upd : amount was non-zero, so cout replaces the carry flag
//   done  : result is final this cycle
module exec_shifter
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
`ifdef EXEC_SHIFT_ITER_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
`endif
    input  shift_op_e         op,
    input  logic [SH_W-1:0]   amt,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              cout,
    output logic              c_upd,
    output logic              done
);

`ifdef EXEC_SHIFT_ITER_EN
    logic              busy_r;
    logic [DATA_W-1:0] val_r;
    logic [SH_W-1:0]   cnt_r;
    logic [DATA_W-1:0] cur_val_s;
    logic [DATA_W-1:0] step_val_s;
    logic [SH_W-1:0]   cur_cnt_s;
    logic              step_c_s;

    // One shift step per cycle; the first cycle works straight from din/amt.
    always_comb begin
        cur_val_s  = busy_r ? val_r : din;
        cur_cnt_s  = busy_r ? cnt_r : amt;
        step_val_s = cur_val_s;
        step_c_s   = cur_val_s[0];
        case (op)
            SH_LSL: begin
                step_val_s = {cur_val_s[DATA_W-2:0], 1'b0};
                step_c_s   = cur_val_s[DATA_W-1];
            end
            SH_LSR:  step_val_s = {1'b0, cur_val_s[DATA_W-1:1]};
            SH_ASR:  step_val_s = {cur_val_s[DATA_W-1], cur_val_s[DATA_W-1:1]};
            SH_ROR:  step_val_s = {cur_val_s[0], cur_val_s[DATA_W-1:1]};
            default: step_val_s = cur_val_s;
        endcase
        if (cur_cnt_s != '0) begin
            dout = step_val_s;
            cout = step_c_s;
        end else begin
            dout = cur_val_s;
            cout = 1'b0;
        end
        c_upd = (amt != '0);
        done  = (cur_cnt_s < SH_W'(2));
    end

    // Iteration state: keep stepping while EX is active and more than one step remains.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            val_r  <= '0;
            cnt_r  <= '0;
        end else if (active && !done) begin
            busy_r <= 1'b1;
            val_r  <= dout;
            cnt_r  <= cur_cnt_s - SH_W'(1);
        end else begin
            busy_r <= 1'b0;
            val_r  <= val_r;
            cnt_r  <= cnt_r;
        end
    end
`else
    logic [DATA_W:0]     lsl_s;
    logic [DATA_W:0]     lsr_s;
    logic [DATA_W:0]     asr_s;
    logic [2*DATA_W-1:0] ror_s;

    // Barrel shift; an extra guard bit on each side captures the carry-out.
    always_comb begin
        lsl_s = {1'b0, din} << amt;
        lsr_s = {din, 1'b0} >> amt;
        asr_s = $unsigned($signed({din, 1'b0}) >>> amt);
        ror_s = {din, din} >> amt;
        case (op)
            SH_LSL: begin
                dout = lsl_s[DATA_W-1:0];
                cout = lsl_s[DATA_W];
            end
            SH_LSR: begin
                dout = lsr_s[DATA_W:1];
                cout = lsr_s[0];
            end
            SH_ASR: begin
                dout = asr_s[DATA_W:1];
                cout = asr_s[0];
            end
            SH_ROR: begin
                dout = ror_s[DATA_W-1:0];
                cout = ror_s[DATA_W-1];
            end
            default: begin
                dout = din;
                cout = 1'b0;
            end
        endcase
        c_upd = (amt != '0);
        done  = 1'b1;
    end
`endif

endmodule

// File: rtl/exec_datapath.sv
// Two-stage execute datapath: OP (register read with bypass) and EX (shift, ALU, writeback).
// Build option: EXEC_SHIFT_ITER_EN makes the shifter iterative (EX stalls for max(1, amt) cycles).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid / in_ready    : operation handshake
//   a_addr, b_addr, s_addr : operand A, operand B, shift-amount register addresses
//   imm_data, shift_imm    : immediate operand B, immediate shift amount
//   sel_a_zero, sel_b_imm, sel_shift_reg : operand source selects
//   shift_op, alu_op       : shifter and ALU operations
//   wr_en, wr_addr         : result writeback (ignored for CMP)
//   flags_en               : update NZCV
//   ld_en, ld_addr, ld_data: external register write port, accepted every cycle
//   out_valid, out_data, out_flags : registered result pulse and NZCV {N,Z,C,V}
module exec_datapath
    import exec_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 16,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] imm_data,
    input  logic [DATA_W-1:0] shift_imm,
    input  logic              sel_a_zero,
    input  logic              sel_b_imm,
    input  logic              sel_shift_reg,
    input  logic [1:0]        shift_op,
    input  logic [2:0]        alu_op,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              flags_en,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_flags
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic              ex_valid_r;
    logic [DATA_W-1:0] ex_a_r;
    logic [DATA_W-1:0] ex_b_r;
    logic [SH_W-1:0]   ex_amt_r;
    shift_op_e         ex_sop_r;
    alu_op_e           ex_aop_r;
    logic              ex_wr_r;
    logic [ADDR_W-1:0] ex_wr_addr_r;
    logic              ex_flags_en_r;
    logic [3:0]        flags_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;

    logic [DATA_W-1:0] a_op_s, b_op_s, s_op_s, res_s, sh_dout_s;
    logic [DATA_W:0]   sum_add_s, sum_sub_s;
    logic [SH_W-1:0]   amt_src_s;
    logic [3:0]        flags_nxt_s;
    logic sh_cout_s, sh_cupd_s, sh_done_s, c_log_s, c_s, v_s;
    logic ex_done_s, ex_fwd_s, in_ready_s, accept_s;

    // Register read with bypass: finishing EX result, then same-cycle ld, then stored value.
    function automatic logic [DATA_W-1:0] fwd_read(
        input logic [ADDR_W-1:0] addr,
        input logic              ex_hit,
        input logic [ADDR_W-1:0] ex_addr,
        input logic [DATA_W-1:0] ex_val,
        input logic              l_hit,
        input logic [ADDR_W-1:0] l_addr,
        input logic [DATA_W-1:0] l_val,
        input logic [DATA_W-1:0] rf_val
    );
        logic [DATA_W-1:0] v;
        if (ex_hit && (ex_addr == addr)) v = ex_val;
        else if (l_hit && (l_addr == addr)) v = l_val;
        else v = rf_val;
        return v;
    endfunction

    // Only the low SH_W bits of a shift-amount source are meaningful.
    function automatic logic [SH_W-1:0] shamt(input logic [DATA_W-1:0] v);
        return v[SH_W-1:0];
    endfunction

    exec_shifter #(.DATA_W(DATA_W), .SH_W(SH_W)) u_shifter (
`ifdef EXEC_SHIFT_ITER_EN
        .clk    (clk),
        .rst    (rst),
        .active (ex_valid_r),
`endif
        .op     (ex_sop_r),
        .amt    (ex_amt_r),
        .din    (ex_b_r),
        .dout   (sh_dout_s),
        .cout   (sh_cout_s),
        .c_upd  (sh_cupd_s),
        .done   (sh_done_s)
    );

    // Handshake and OP-stage operand selection.
    always_comb begin
        ex_done_s  = ex_valid_r && sh_done_s;
        ex_fwd_s   = ex_done_s && ex_wr_r;
        in_ready_s = !rst && (!ex_valid_r || sh_done_s);
        accept_s   = in_valid && in_ready_s;
        a_op_s = fwd_read(a_addr, ex_fwd_s, ex_wr_addr_r, res_s, ld_en, ld_addr, ld_data, regs_r[a_addr]);
        b_op_s = fwd_read(b_addr, ex_fwd_s, ex_wr_addr_r, res_s, ld_en, ld_addr, ld_data, regs_r[b_addr]);
        s_op_s = fwd_read(s_addr, ex_fwd_s, ex_wr_addr_r, res_s, ld_en, ld_addr, ld_data, regs_r[s_addr]);
        amt_src_s = sel_shift_reg ? shamt(s_op_s) : shamt(shift_imm);
    end

    // EX-stage ALU and next NZCV; logical ops take C from the shifter unless the amount was zero.
    always_comb begin
        sum_add_s = {1'b0, ex_a_r} + {1'b0, sh_dout_s};
        sum_sub_s = {1'b0, ex_a_r} + {1'b0, ~sh_dout_s} + {{DATA_W{1'b0}}, 1'b1};
        c_log_s   = sh_cupd_s ? sh_cout_s : flags_r[FLAG_C];
        res_s     = '0;
        c_s       = c_log_s;
        v_s       = flags_r[FLAG_V];
        case (ex_aop_r)
            ALU_ADD: begin
                res_s = sum_add_s[DATA_W-1:0];
                c_s   = sum_add_s[DATA_W];
                v_s   = signed_ovf(ex_a_r[DATA_W-1], sh_dout_s[DATA_W-1], sum_add_s[DATA_W-1]);
            end
            ALU_SUB, ALU_CMP: begin
                res_s = sum_sub_s[DATA_W-1:0];
                c_s   = sum_sub_s[DATA_W];
                v_s   = signed_ovf(ex_a_r[DATA_W-1], ~sh_dout_s[DATA_W-1], sum_sub_s[DATA_W-1]);
            end
            ALU_AND: res_s = ex_a_r & sh_dout_s;
            ALU_ORR: res_s = ex_a_r | sh_dout_s;
            ALU_EOR: res_s = ex_a_r ^ sh_dout_s;
            ALU_MOV: res_s = sh_dout_s;
            ALU_MVN: res_s = ~sh_dout_s;
            default: res_s = '0;
        endcase
        flags_nxt_s         = flags_r;
        flags_nxt_s[FLAG_N] = res_s[DATA_W-1];
        flags_nxt_s[FLAG_Z] = (res_s == '0);
        flags_nxt_s[FLAG_C] = c_s;
        flags_nxt_s[FLAG_V] = v_s;
    end

    // EX pipeline register; an immediate B bypasses the shifter by forcing a zero amount.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r    <= 1'b0;
            ex_a_r        <= '0;
            ex_b_r        <= '0;
            ex_amt_r      <= '0;
            ex_sop_r      <= SH_LSL;
            ex_aop_r      <= ALU_ADD;
            ex_wr_r       <= 1'b0;
            ex_wr_addr_r  <= '0;
            ex_flags_en_r <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r    <= 1'b1;
            ex_a_r        <= sel_a_zero ? '0 : a_op_s;
            ex_b_r        <= sel_b_imm ? imm_data : b_op_s;
            ex_amt_r      <= sel_b_imm ? '0 : amt_src_s;
            ex_sop_r      <= shift_op_e'(shift_op);
            ex_aop_r      <= alu_op_e'(alu_op);
            ex_wr_r       <= wr_en && (alu_op != ALU_CMP);
            ex_wr_addr_r  <= wr_addr;
            ex_flags_en_r <= flags_en;
        end else if (ex_done_s) begin
            ex_valid_r    <= 1'b0;
        end else begin
            ex_valid_r    <= ex_valid_r;
        end
    end

    // Writeback: register file (EX wins over ld on the same address), flags and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            flags_r     <= 4'b0000;
            for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
        end else begin
            out_valid_r <= ex_done_s;
            out_data_r  <= ex_done_s ? res_s : out_data_r;
            flags_r     <= (ex_done_s && ex_flags_en_r) ? flags_nxt_s : flags_r;
            for (int i = 0; i < NREGS; i++) begin
                if (ex_fwd_s && (ex_wr_addr_r == ADDR_W'(i))) regs_r[i] <= res_s;
                else if (ld_en && (ld_addr == ADDR_W'(i))) regs_r[i] <= ld_data;
                else regs_r[i] <= regs_r[i];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_flags = flags_r;

endmodule
